bcd_seq_converter: RTL and testbench

//  Multi-cycle binary-to-BCD converter using the iterative double-dabble method (add 3 to digits >=5, shift left).

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_dabble_step.sv | 30 +++
 rtl/bcd_seq_converter.sv | 120 ++++++++++++
 tb/tb_bcd_seq_converter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

    // Double-dabble digit correction: a digit of 5 or more would exceed 9
    // after the following doubling, so pre-add 3 (4-bit wrap, no carry out).
    function automatic logic [BCD_NIBBLE_W-1:0] add3_nibble(input logic [BCD_NIBBLE_W-1:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: correct every BCD digit, then shift left by one.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic [BCD_NIBBLE_W*DIGITS+BIN_W-1:0] sr_in,
    output logic [BCD_NIBBLE_W*DIGITS+BIN_W-1:0] sr_out
);

    localparam int SR_W = BCD_NIBBLE_W*DIGITS + BIN_W;

    logic [SR_W-1:0] adj;

    // Binary part passes through untouched; only the BCD digits are corrected.
    assign adj[BIN_W-1:0] = sr_in[BIN_W-1:0];

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            assign adj[BIN_W+BCD_NIBBLE_W*k +: BCD_NIBBLE_W] =
                add3_nibble(sr_in[BIN_W+BCD_NIBBLE_W*k +: BCD_NIBBLE_W]);
        end
    endgenerate

    // The MSB of the corrected word is dropped by the shift; digit sizing guarantees it is zero.
    assign sr_out = adj << 1;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter: one double-dabble step per clock,
// valid/ready handshakes on both sides, back-to-back accept when a result retires.
module bcd_seq_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);
    import bcd_pkg::*;

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    // Reject configurations whose digit count cannot hold 2^BIN_W-1 (log10(2) ~ 0.30103).
    generate
        if (BIN_W < 1) begin : g_binw_chk
            $error("bcd_seq_converter: BIN_W must be at least 1");
        end
        if (DIGITS < (BIN_W*30103 + 99999) / 100000) begin : g_digits_chk
            $error("bcd_seq_converter: DIGITS too small for BIN_W");
        end
    endgenerate

    bcd_state_t             state_q, state_d;
    logic [SR_W-1:0]        sr_q, sr_d, sr_step;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0]       out_bcd_q, out_bcd_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .sr_in  (sr_q),
        .sr_out (sr_step)
    );

    // Ready is a pure function of state and out_ready, never of in_valid.
    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign busy      = busy_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_bcd_d   = out_bcd_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sr_d    = {{BCD_W{1'b0}}, in_bin};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    out_bcd_d   = sr_step[SR_W-1 -: BCD_W];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        sr_d    = {{BCD_W{1'b0}}, in_bin};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CONVERT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All FSM state and outputs; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: 8-bit/3-digit, 16-bit/5-digit and 1-bit/1-digit instances.
module tb_bcd_seq_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: BIN_W=8, DIGITS=3
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_busy;
    logic [7:0]  a_in_bin = '0;
    logic [11:0] a_out_bcd;

    // Instance B: BIN_W=16, DIGITS=5
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_busy;
    logic [15:0] b_in_bin = '0;
    logic [19:0] b_out_bcd;

    // Instance C: BIN_W=1, DIGITS=1
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_busy;
    logic [0:0]  c_in_bin = '0;
    logic [3:0]  c_out_bcd;

    int checks = 0;
    int errors = 0;

    bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bcd(a_out_bcd), .busy(a_busy)
    );

    bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd), .busy(b_busy)
    );

    bcd_seq_converter #(.BIN_W(1), .DIGITS(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bin(c_in_bin),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bcd(c_out_bcd), .busy(c_busy)
    );

    // Reference: decimal digits by plain division, packed one per nibble.
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Convert one operand on instance A, then hold the result for 'stall' cycles before retiring it.
    task automatic run_a(input int v, input int stall);
        int n, lat, bc;
        n = 0;
        a_out_ready = (stall == 0);
        while (!a_in_ready && n < 50) begin step(); n++; end
        chk("a_ready_wait", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_bin   = v[7:0];
        step();
        a_in_valid = 1'b0;
        lat = 0;
        bc  = int'(a_busy);
        while (!a_out_valid && lat < 60) begin
            step();
            lat++;
            if (!a_out_valid) bc += int'(a_busy);
        end
        chk("a_latency", 32'(lat), 32'd8);
        chk("a_busy_cycles", 32'(bc), 32'd8);
        chk("a_result", 32'(a_out_bcd), to_bcd(v));
        for (int s = 0; s < stall; s++) begin
            step();
            chk("a_hold_valid", 32'(a_out_valid), 32'd1);
            chk("a_hold_bcd", 32'(a_out_bcd), to_bcd(v));
            chk("a_hold_in_ready", 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1'b1;
        step();
        chk("a_retired", 32'(a_out_valid), 32'd0);
    endtask

    task automatic run_b(input int v);
        int n, lat;
        n = 0;
        while (!b_in_ready && n < 50) begin step(); n++; end
        b_in_valid = 1'b1;
        b_in_bin   = v[15:0];
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 80) begin step(); lat++; end
        chk("b_latency", 32'(lat), 32'd16);
        chk("b_result", 32'(b_out_bcd), to_bcd(v));
        step();
        chk("b_retired", 32'(b_out_valid), 32'd0);
    endtask

    initial begin
        int lat, gap, v;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_bcd", 32'(a_out_bcd), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(a_in_ready), 32'd1);
        step();

        // T1 / T2 directed values including the maximum
        run_a(255, 0);
        run_a(0, 0);
        run_a(5, 0);
        run_a(99, 0);

        // T3: long back-pressure
        run_a(137, 20);

        // T4: back-to-back accept on retire
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_bin    = 8'd42;
        step();
        a_in_bin = 8'd200;
        lat = 0;
        while (!a_out_valid && lat < 60) begin step(); lat++; end
        chk("t4_lat", 32'(lat), 32'd8);
        chk("t4_first", 32'(a_out_bcd), 32'h042);
        chk("t4_in_ready_on_retire", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 1'b0;
        chk("t4_valid_drop", 32'(a_out_valid), 32'd0);
        chk("t4_busy_again", 32'(a_busy), 32'd1);
        gap = 1;
        while (!a_out_valid && gap < 60) begin step(); gap++; end
        chk("t4_gap", 32'(gap), 32'd9);
        chk("t4_second", 32'(a_out_bcd), 32'h200);
        step();

        // T5: asynchronous reset mid-conversion
        a_in_valid = 1'b1;
        a_in_bin   = 8'd250;
        step();
        a_in_valid = 1'b0;
        repeat (4) step();
        chk("t5_busy_before", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(a_out_valid), 32'd0);
        chk("t5_out_bcd", 32'(a_out_bcd), 32'd0);
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_in_ready", 32'(a_in_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        run_a(7, 0);

        // Full sweep of every 8-bit operand
        for (int i = 0; i < 256; i++) run_a(i, 0);

        // Random operands with random back-pressure
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 255));
            run_a(v, int'($urandom_range(0, 3)));
        end

        // T6: wide instance
        run_b(65535);
        run_b(0);
        for (int i = 0; i < 10; i++) run_b(int'($urandom_range(0, 65535)));

        // BIN_W=1 converts in a single CONVERT cycle
        for (int i = 0; i < 2; i++) begin
            c_in_valid = 1'b1;
            c_in_bin   = 1'(i);
            step();
            c_in_valid = 1'b0;
            chk("c_busy", 32'(c_busy), 32'd1);
            step();
            chk("c_valid", 32'(c_out_valid), 32'd1);
            chk("c_result", 32'(c_out_bcd), to_bcd(i));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
